spatz_xif_seq_checker: RTL and testbench

- Parametrised, self-checking X-interface sequencer for Spatz block-level benches and FPGA bring-up.
- Holds a loadable program of instructions, each with an rs1 operand and expected result/exception.
- Issues the program to the Spatz X-interface with a full valid/ready handshake and keeps up to MaxOutstanding writebacks in flight.
- Checks every response in order and reports an error count and a pass flag.

---
 rtl/spatz_xif_seq_checker.sv | 174 +++++++++++++++++
 tb/tb_spatz_xif_seq_checker.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatz_xif_seq_checker.sv
// spatz_xif_seq_checker: self-checking X-interface sequencer that issues a loaded program and checks responses in order
// Ports:
//   clk_i, rst_ni                  clock, asynchronous active-low reset
//   prog_we_i/addr/instr/rs1/exp/flags  program load (accepted only when not busy)
//   num_instr_i, start_i           run length and start pulse
//   busy_o, done_o, pass_o, err_cnt_o  run status and saturating error count
//   x_issue_*, x_result_*          Spatz X-interface issue and result channels
// Optional: define SPATZ_XIF_CHK_TIMEOUT_EN for a handshake watchdog with output timeout_o.
module spatz_xif_seq_checker #(
    parameter int unsigned NumEntries     = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned ErrCntWidth    = 8,
    parameter int unsigned TimeoutCycles  = 64
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          prog_we_i,
    input  logic [$clog2(NumEntries)-1:0] prog_addr_i,
    input  logic [31:0]                   prog_instr_i,
    input  logic [DataWidth-1:0]          prog_rs1_i,
    input  logic [DataWidth-1:0]          prog_exp_i,
    input  logic [2:0]                    prog_flags_i,
    input  logic [$clog2(NumEntries):0]   num_instr_i,
    input  logic                          start_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          pass_o,
    output logic [ErrCntWidth-1:0]        err_cnt_o,
`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
    output logic                          timeout_o,
`endif
    output logic                          x_issue_valid_o,
    input  logic                          x_issue_ready_i,
    output logic [31:0]                   x_issue_instr_o,
    output logic [DataWidth-1:0]          x_issue_rs1_o,
    output logic [IdWidth-1:0]            x_issue_id_o,
    input  logic                          x_issue_exc_i,
    input  logic                          x_result_valid_i,
    output logic                          x_result_ready_o,
    input  logic [IdWidth-1:0]            x_result_id_i,
    input  logic [DataWidth-1:0]          x_result_data_i
);
    localparam int unsigned AW = $clog2(NumEntries);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned FW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam int unsigned EW = ErrCntWidth + 2;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    state_e r_state, w_state_nxt;

    logic [31:0]          r_mem_instr [NumEntries];
    logic [DataWidth-1:0] r_mem_rs1   [NumEntries];
    logic [DataWidth-1:0] r_mem_exp   [NumEntries];
    logic [2:0]           r_mem_flags [NumEntries];
    logic [IdWidth-1:0]   r_fifo_id   [MaxOutstanding];
    logic [DataWidth-1:0] r_fifo_exp  [MaxOutstanding];
    logic                 r_fifo_chk  [MaxOutstanding];

    logic [PW-1:0]          r_pc;
    logic [FW-1:0]          r_wr, r_rd, w_wr_nxt, w_rd_nxt;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [ErrCntWidth-1:0] r_err;
    logic [EW-1:0]          w_err_sum;
    logic [2:0]             w_flags;
    logic w_run, w_start, w_full, w_empty, w_issue_hs, w_res_hs, w_push, w_pop, w_last;
    logic w_err_iss, w_err_res, w_tmo;

    assign w_run      = (r_state == ISSUE) || (r_state == DRAIN);
    assign w_start    = start_i && !w_run;
    assign w_flags    = r_mem_flags[r_pc[AW-1:0]];
    assign w_full     = r_cnt == CW'(MaxOutstanding);
    assign w_empty    = r_cnt == '0;
    assign w_issue_hs = x_issue_valid_o && x_issue_ready_i;
    assign w_res_hs   = x_result_valid_i && x_result_ready_o;
    assign w_push     = w_issue_hs && w_flags[0] && !x_issue_exc_i;
    // A result with nothing outstanding is flagged but never pops, so the FIFO cannot underflow
    assign w_pop      = w_res_hs && !w_empty;
    assign w_last     = (r_pc + PW'(1)) == num_instr_i;
    assign w_err_iss  = w_issue_hs && (x_issue_exc_i != w_flags[1]);
    assign w_err_res  = w_res_hs && (w_empty || x_result_id_i != r_fifo_id[r_rd] ||
                        (r_fifo_chk[r_rd] && x_result_data_i != r_fifo_exp[r_rd]));
    assign w_cnt_nxt  = r_cnt + CW'(w_push) - CW'(w_pop);
    assign w_wr_nxt   = (r_wr == FW'(MaxOutstanding - 1)) ? '0 : r_wr + FW'(1);
    assign w_rd_nxt   = (r_rd == FW'(MaxOutstanding - 1)) ? '0 : r_rd + FW'(1);
    assign w_err_sum  = EW'(r_err) + EW'(w_err_iss) + EW'(w_err_res) + EW'(w_tmo);

`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TimeoutCycles + 1);
    logic [TW-1:0] r_wdog;
    logic          r_timeout;
    // Fires on the TimeoutCycles-th consecutive running cycle without any handshake
    assign w_tmo     = w_run && !w_issue_hs && !w_res_hs && (r_wdog == TW'(TimeoutCycles - 1));
    assign timeout_o = r_timeout;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_wdog    <= (!w_run || w_issue_hs || w_res_hs || w_tmo) ? '0 : r_wdog + TW'(1);
            r_timeout <= w_start ? 1'b0 : (r_timeout || w_tmo);
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (prog_we_i && !w_run) begin
            r_mem_instr[prog_addr_i] <= prog_instr_i;
            r_mem_rs1[prog_addr_i]   <= prog_rs1_i;
            r_mem_exp[prog_addr_i]   <= prog_exp_i;
            r_mem_flags[prog_addr_i] <= prog_flags_i;
        end
        if (w_push) begin
            r_fifo_id[r_wr]  <= x_issue_id_o;
            r_fifo_exp[r_wr] <= r_mem_exp[r_pc[AW-1:0]];
            r_fifo_chk[r_wr] <= w_flags[2];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc  <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= '0;
        end else if (w_start) begin
            r_pc  <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            r_pc  <= w_issue_hs ? r_pc + PW'(1) : r_pc;
            r_wr  <= w_tmo ? '0 : (w_push ? w_wr_nxt : r_wr);
            r_rd  <= w_tmo ? '0 : (w_pop ? w_rd_nxt : r_rd);
            r_cnt <= w_tmo ? '0 : w_cnt_nxt;
            r_err <= (w_err_sum > EW'({ErrCntWidth{1'b1}})) ? '1 : w_err_sum[ErrCntWidth-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: if (start_i) w_state_nxt = (num_instr_i == '0) ? DONE : ISSUE;
            ISSUE:      if (w_issue_hs && w_last) w_state_nxt = DRAIN;
            DRAIN:      if (w_cnt_nxt == '0) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
        if (w_tmo) w_state_nxt = DONE;
    end

    always_comb begin
        busy_o           = w_run;
        done_o           = r_state == DONE;
        pass_o           = (r_state == DONE) && (r_err == '0);
        err_cnt_o        = r_err;
        x_result_ready_o = w_run;
        // Valid depends only on registered state, so the issue fields hold while waiting for ready
        x_issue_valid_o  = (r_state == ISSUE) && (r_pc < num_instr_i) && !w_full;
        x_issue_instr_o  = x_issue_valid_o ? r_mem_instr[r_pc[AW-1:0]] : '0;
        x_issue_rs1_o    = x_issue_valid_o ? r_mem_rs1[r_pc[AW-1:0]] : '0;
        x_issue_id_o     = x_issue_valid_o ? IdWidth'(r_pc) : '0;
    end
endmodule

// File: tb/tb_spatz_xif_seq_checker.sv
// tb_spatz_xif_seq_checker: table vectors, directed corner sequences and randomized runs against a queue-based reference
module tb_spatz_xif_seq_checker;
    localparam int NE = 32, DW = 32, IW = 4, MO = 2, EW = 4, TO = 16;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          prog_we_i = 1'b0;
    logic [4:0]    prog_addr_i = '0;
    logic [31:0]   prog_instr_i = '0;
    logic [DW-1:0] prog_rs1_i = '0;
    logic [DW-1:0] prog_exp_i = '0;
    logic [2:0]    prog_flags_i = '0;
    logic [5:0]    num_instr_i = '0;
    logic          start_i = 1'b0;
    logic          busy_o, done_o, pass_o;
    logic [EW-1:0] err_cnt_o;
    logic          x_issue_valid_o;
    logic          x_issue_ready_i = 1'b0;
    logic [31:0]   x_issue_instr_o;
    logic [DW-1:0] x_issue_rs1_o;
    logic [IW-1:0] x_issue_id_o;
    logic          x_issue_exc_i = 1'b0;
    logic          x_result_valid_i = 1'b0;
    logic          x_result_ready_o;
    logic [IW-1:0] x_result_id_i = '0;
    logic [DW-1:0] x_result_data_i = '0;
`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
    logic          timeout_o;
`endif

    always #5 clk_i = ~clk_i;

    spatz_xif_seq_checker #(
        .NumEntries(NE), .DataWidth(DW), .IdWidth(IW),
        .MaxOutstanding(MO), .ErrCntWidth(EW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i), .prog_instr_i(prog_instr_i),
        .prog_rs1_i(prog_rs1_i), .prog_exp_i(prog_exp_i), .prog_flags_i(prog_flags_i),
        .num_instr_i(num_instr_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .err_cnt_o(err_cnt_o),
`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .x_issue_valid_o(x_issue_valid_o), .x_issue_ready_i(x_issue_ready_i),
        .x_issue_instr_o(x_issue_instr_o), .x_issue_rs1_o(x_issue_rs1_o),
        .x_issue_id_o(x_issue_id_o), .x_issue_exc_i(x_issue_exc_i),
        .x_result_valid_i(x_result_valid_i), .x_result_ready_o(x_result_ready_o),
        .x_result_id_i(x_result_id_i), .x_result_data_i(x_result_data_i)
    );

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  flags;
        logic        exc;
        logic [31:0] data;
        logic [3:0]  idx;
        int          err;
        logic        pass;
    } vec_t;
    typedef struct { logic [3:0] id; logic [31:0] data; } rsp_t;
    typedef struct { logic [3:0] id; logic [31:0] exp; logic chk; } exp_t;

    vec_t        vecs [10];
    logic [31:0] p_instr [NE];
    logic [31:0] p_rs1 [NE];
    logic [31:0] p_exp [NE];
    logic [2:0]  p_flags [NE];
    logic        e_exc [NE];
    logic [31:0] e_data [NE];
    logic [3:0]  e_idx [NE];
    int checks = 0;
    int failures = 0;
    int g_iss_hold;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic load(input int a, input logic [31:0] ins, input logic [31:0] rs1,
                        input logic [31:0] ex, input logic [2:0] fl);
        prog_we_i = 1'b1;
        prog_addr_i = 5'(a);
        prog_instr_i = ins;
        prog_rs1_i = rs1;
        prog_exp_i = ex;
        prog_flags_i = fl;
        @(negedge clk_i);
        prog_we_i = 1'b0;
        p_instr[a] = ins;
        p_rs1[a] = rs1;
        p_exp[a] = ex;
        p_flags[a] = fl;
        e_exc[a] = fl[1];
        e_data[a] = ex;
        e_idx[a] = '0;
    endtask

    // Acts as the Spatz core: answers each pushed instruction in order with e_data/e_idx,
    // and counts the errors the rules predict for that response script.
    task automatic run(input int n, input int rdy_pct, input int res_pct, input int hold,
                       input bit spur, output int merr);
        rsp_t rq[$];
        exp_t eq[$];
        rsp_t r;
        exp_t e;
        int issued, outst, cyc;
        logic rdy, rv;
        issued = 0; outst = 0; cyc = 0; merr = 0; g_iss_hold = -1;
        num_instr_i = 6'(n);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        while (!done_o && cyc < 3000) begin
            if (cyc == hold) g_iss_hold = issued;
            chk("issue_valid", x_issue_valid_o, (issued < n) && (outst < MO));
            chk("result_ready", x_result_ready_o, 1);
            if (x_issue_valid_o && issued < n) begin
                chk("issue_instr", x_issue_instr_o, p_instr[issued]);
                chk("issue_rs1", x_issue_rs1_o, p_rs1[issued]);
                chk("issue_id", x_issue_id_o, issued % 16);
            end
            rdy = $urandom_range(99) < rdy_pct;
            rv = 1'b0;
            r.id = '0;
            r.data = '0;
            if (spur && cyc == 0) begin
                rdy = 1'b0;
                rv = 1'b1;
                r.id = 4'd3;
                merr++;
            end else if (rq.size() > 0 && cyc >= hold && $urandom_range(99) < res_pct) begin
                rv = 1'b1;
                r = rq[0];
            end
            x_issue_ready_i = rdy;
            x_issue_exc_i = (issued < n) ? e_exc[issued] : 1'b0;
            x_result_valid_i = rv;
            x_result_id_i = r.id;
            x_result_data_i = r.data;
            prog_we_i = $urandom_range(3) == 0;
            prog_addr_i = 5'($urandom);
            prog_instr_i = $urandom;
            start_i = $urandom_range(7) == 0;
            if (x_issue_valid_o && rdy && issued < n) begin
                if (e_exc[issued] != p_flags[issued][1]) merr++;
                if (p_flags[issued][0] && !e_exc[issued]) begin
                    r.id = 4'(issued) ^ e_idx[issued];
                    r.data = e_data[issued];
                    rq.push_back(r);
                    e.id = 4'(issued);
                    e.exp = p_exp[issued];
                    e.chk = p_flags[issued][2];
                    eq.push_back(e);
                    outst++;
                end
                issued++;
            end
            if (rv && !(spur && cyc == 0)) begin
                r = rq.pop_front();
                e = eq.pop_front();
                outst--;
                if (r.id != e.id || (e.chk && r.data != e.exp)) merr++;
            end
            @(negedge clk_i);
            cyc++;
        end
        prog_we_i = 1'b0;
        start_i = 1'b0;
        x_issue_ready_i = 1'b0;
        x_result_valid_i = 1'b0;
        chk("done_reached", done_o, 1);
        chk("all_issued", issued, n);
        chk("all_answered", rq.size(), 0);
        chk("busy_low_done", busy_o, 0);
        chk("ready_low_done", x_result_ready_o, 0);
    endtask

    initial begin
        int n, m, ex_err;
        vecs[0] = '{32'h0c257557, 3'b101, 1'b0, 32'd128, 4'h0, 0, 1'b1};
        vecs[1] = '{32'hc2012173, 3'b101, 1'b0, 32'd127, 4'h0, 1, 1'b0};
        vecs[2] = '{32'hc2012173, 3'b001, 1'b0, 32'd127, 4'h0, 0, 1'b1};
        vecs[3] = '{32'h00812174, 3'b010, 1'b1, 32'd0,   4'h0, 0, 1'b1};
        vecs[4] = '{32'h00812174, 3'b010, 1'b0, 32'd0,   4'h0, 1, 1'b0};
        vecs[5] = '{32'hc2012173, 3'b101, 1'b1, 32'd0,   4'h0, 1, 1'b0};
        vecs[6] = '{32'hc2012173, 3'b011, 1'b1, 32'd0,   4'h0, 0, 1'b1};
        vecs[7] = '{32'hc2012173, 3'b101, 1'b0, 32'd128, 4'h5, 1, 1'b0};
        vecs[8] = '{32'hc2012173, 3'b111, 1'b0, 32'd127, 4'h0, 2, 1'b0};
        vecs[9] = '{32'h0c257557, 3'b100, 1'b0, 32'd999, 4'h0, 0, 1'b1};

        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_pass", pass_o, 0);
        chk("rst_err", err_cnt_o, 0);
        chk("rst_valid", x_issue_valid_o, 0);
        chk("rst_ready", x_result_ready_o, 0);
        chk("rst_id", x_issue_id_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        for (int i = 0; i < 10; i++) begin
            load(0, vecs[i].instr, 32'd256, 32'd128, vecs[i].flags);
            e_exc[0] = vecs[i].exc;
            e_data[0] = vecs[i].data;
            e_idx[0] = vecs[i].idx;
            run(1, 100, 100, 0, 1'b0, m);
            chk($sformatf("vec%0d_err", i), err_cnt_o, vecs[i].err);
            chk($sformatf("vec%0d_pass", i), pass_o, vecs[i].pass);
        end

        load(0, 32'h0c257557, 32'd256, 32'd128, 3'b101);
        load(1, 32'hc2012173, 32'd0, 32'd128, 3'b101);
        run(2, 100, 100, 0, 1'b0, m);
        chk("vset_csr_err", err_cnt_o, 0);
        chk("vset_csr_pass", pass_o, 1);

        for (int i = 0; i < 4; i++) load(i, 32'hc2012173, i, 3 * i, 3'b101);
        run(4, 100, 100, 10, 1'b0, m);
        chk("bp_issued_while_held", g_iss_hold, 2);
        chk("bp_err", err_cnt_o, 0);
        chk("bp_pass", pass_o, 1);

        load(0, 32'h00000013, 32'd0, 32'd0, 3'b000);
        load(1, 32'hc2012173, 32'd0, 32'd7, 3'b101);
        run(2, 100, 100, 0, 1'b1, m);
        chk("spurious_err", err_cnt_o, 1);

        load(0, 32'hc2012173, 32'd0, 32'd5, 3'b101);
        load(1, 32'hc2012173, 32'd0, 32'd6, 3'b101);
        e_idx[1] = 4'h2;
        run(2, 100, 100, 0, 1'b0, m);
        chk("id_mismatch_err", err_cnt_o, 1);

        for (int i = 0; i < 20; i++) begin
            load(i, 32'hc2012173, 32'd0, i, 3'b101);
            e_exc[i] = 1'b1;
        end
        run(20, 100, 100, 0, 1'b0, m);
        chk("saturate_err", err_cnt_o, 15);
        chk("saturate_pass", pass_o, 0);

        num_instr_i = '0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("zero_done", done_o, 1);
        chk("zero_busy", busy_o, 0);
        chk("zero_err", err_cnt_o, 0);
        chk("zero_pass", pass_o, 1);

        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(NE, 1);
            for (int i = 0; i < n; i++) begin
                load(i, $urandom, $urandom, $urandom, 3'($urandom));
                if ($urandom_range(99) < 15) e_exc[i] = !e_exc[i];
                if ($urandom_range(99) < 20) e_data[i] = p_exp[i] ^ 32'h10;
                if ($urandom_range(99) < 10) e_idx[i] = 4'h1;
            end
            run(n, $urandom_range(100, 60), $urandom_range(100, 60), 0, t == 3, m);
            ex_err = (m > 15) ? 15 : m;
            chk($sformatf("rand%0d_err", t), err_cnt_o, ex_err);
            chk($sformatf("rand%0d_pass", t), pass_o, m == 0);
        end

`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
        load(0, 32'h0c257557, 32'd256, 32'd128, 3'b101);
        num_instr_i = 6'd1;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (15) @(negedge clk_i);
        chk("tmo_early", done_o, 0);
        @(negedge clk_i);
        chk("tmo_done", done_o, 1);
        chk("tmo_flag", timeout_o, 1);
        chk("tmo_err", err_cnt_o, 1);
        chk("tmo_pass", pass_o, 0);
        run(1, 100, 100, 0, 1'b0, m);
        chk("tmo_cleared", timeout_o, 0);
        chk("tmo_rerun_err", err_cnt_o, 0);
`endif

        for (int i = 0; i < 8; i++) load(i, 32'hc2012173, i, i, 3'b111);
        num_instr_i = 6'd8;
        x_issue_ready_i = 1'b1;
        x_issue_exc_i = 1'b0;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("pre_reset_err", err_cnt_o, 2);
        #2 rst_ni = 1'b0;
        #1;
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_err", err_cnt_o, 0);
        chk("mid_rst_valid", x_issue_valid_o, 0);
        chk("mid_rst_ready", x_result_ready_o, 0);
        chk("mid_rst_instr", x_issue_instr_o, 0);
`ifdef SPATZ_XIF_CHK_TIMEOUT_EN
        chk("mid_rst_tmo", timeout_o, 0);
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        x_issue_ready_i = 1'b0;
        @(negedge clk_i);
        chk("post_rst_idle_busy", busy_o, 0);
        chk("post_rst_idle_done", done_o, 0);
        load(0, 32'h0c257557, 32'd256, 32'd128, 3'b101);
        run(1, 100, 100, 0, 1'b0, m);
        chk("post_rst_err", err_cnt_o, 0);
        chk("post_rst_pass", pass_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
